// File: rtl/load_extend_unit.sv
// load_extend_unit: formats memory read data into a register write-back value.
// It selects a byte, halfword or word at any byte offset, then sign- or
// zero-extends it. A load that crosses a word boundary is built from two beats.
module load_extend_unit #(
   parameter int unsigned DATA_WIDTH       = 32,
   parameter bit          ALLOW_MISALIGNED = 1'b1,
   parameter int unsigned OFS_W            = $clog2(DATA_WIDTH / 8)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [OFS_W-1:0]      in_offset,
   input  logic [2:0]            in_control,
   output logic                  need_second,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_misaligned,
   output logic                  out_fault
);

   localparam int unsigned BYTES = DATA_WIDTH / 8;
   localparam int unsigned IW    = $clog2(2 * DATA_WIDTH);

   typedef enum logic {
      IDLE,
      WAIT2
   } state_t;

   state_t                state_q;
   logic [DATA_WIDTH-1:0] first_q;
   logic [OFS_W-1:0]      ofs_q;
   logic [2:0]            ctl_q;
   logic                  out_valid_q;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic                  out_mis_q;
   logic                  out_fault_q;

   logic [DATA_WIDTH-1:0]   lo_w;
   logic [DATA_WIDTH-1:0]   hi_w;
   logic [2*DATA_WIDTH-1:0] wide;
   logic [DATA_WIDTH-1:0]   sel;
   logic [OFS_W-1:0]        ofs_e;
   logic [2:0]              ctl_e;
   int unsigned             size_b;
   logic                    straddle;
   logic [DATA_WIDTH-1:0]   ext_data_d;
   logic                    accept;

   // The output register can take a new result whenever it is empty or draining.
   assign in_ready    = !out_valid_q || out_ready;
   assign accept      = in_valid && in_ready;
   assign need_second = (state_q == WAIT2);

   assign out_valid      = out_valid_q;
   assign out_data       = out_data_q;
   assign out_misaligned = out_mis_q;
   assign out_fault      = out_fault_q;

   // Field selection and extension; in WAIT2 the latched first beat and its
   // offset/type are combined with the incoming second beat.
   always_comb begin
      lo_w   = (state_q == WAIT2) ? first_q : in_data;
      hi_w   = (state_q == WAIT2) ? in_data : '0;
      ofs_e  = (state_q == WAIT2) ? ofs_q : in_offset;
      ctl_e  = (state_q == WAIT2) ? ctl_q : in_control;
      wide   = {hi_w, lo_w};
      sel    = '0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         sel[i] = wide[IW'(32'(ofs_e) * 8 + i)];
      end
      case (ctl_e)
         3'd1, 3'd3: size_b = 2;
         3'd2, 3'd4: size_b = 1;
         default:    size_b = BYTES;
      endcase
      straddle = (32'(ofs_e) + size_b) > BYTES;
      case (ctl_e)
         3'd1:    ext_data_d = {{(DATA_WIDTH-16){sel[15]}}, sel[15:0]};
         3'd2:    ext_data_d = {{(DATA_WIDTH-8){sel[7]}}, sel[7:0]};
         3'd3:    ext_data_d = {{(DATA_WIDTH-16){1'b0}}, sel[15:0]};
         3'd4:    ext_data_d = {{(DATA_WIDTH-8){1'b0}}, sel[7:0]};
         default: ext_data_d = sel;
      endcase
   end

   // Access FSM and registered result; a load and a drain may share one edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         first_q     <= '0;
         ofs_q       <= '0;
         ctl_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_mis_q   <= 1'b0;
         out_fault_q <= 1'b0;
      end else if (accept) begin
         if (state_q == WAIT2) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b1;
            out_data_q  <= ext_data_d;
            out_mis_q   <= 1'b1;
            out_fault_q <= 1'b0;
         end else if (straddle && ALLOW_MISALIGNED) begin
            // accept implies any pending result is draining this edge
            state_q     <= WAIT2;
            first_q     <= in_data;
            ofs_q       <= in_offset;
            ctl_q       <= in_control;
            out_valid_q <= 1'b0;
         end else if (straddle) begin
            out_valid_q <= 1'b1;
            out_data_q  <= '0;
            out_mis_q   <= 1'b0;
            out_fault_q <= 1'b1;
         end else begin
            out_valid_q <= 1'b1;
            out_data_q  <= ext_data_d;
            out_mis_q   <= 1'b0;
            out_fault_q <= 1'b0;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_load_extend_unit.sv
// Directed bench for load_extend_unit: one instance with straddling loads
// enabled and one with straddling loads faulted.
module tb_load_extend_unit;

   localparam int unsigned DW = 32;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          flt_in_valid;
   logic [DW-1:0] in_data;
   logic [1:0]    in_offset;
   logic [2:0]    in_control;
   logic          out_ready;

   logic          in_ready, need_second, out_valid, out_mis, out_fault;
   logic [DW-1:0] out_data;
   logic          f_in_ready, f_need_second, f_out_valid, f_out_mis, f_out_fault;
   logic [DW-1:0] f_out_data;

   int compared;
   int mismatched;

   load_extend_unit #(.DATA_WIDTH(DW), .ALLOW_MISALIGNED(1'b1)) u_dut (
      .clock(clk), .reset(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_offset(in_offset), .in_control(in_control),
      .need_second(need_second),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_misaligned(out_mis), .out_fault(out_fault)
   );

   load_extend_unit #(.DATA_WIDTH(DW), .ALLOW_MISALIGNED(1'b0)) u_flt (
      .clock(clk), .reset(rst_n),
      .in_valid(flt_in_valid), .in_ready(f_in_ready),
      .in_data(in_data), .in_offset(in_offset), .in_control(in_control),
      .need_second(f_need_second),
      .out_valid(f_out_valid), .out_ready(out_ready),
      .out_data(f_out_data), .out_misaligned(f_out_mis), .out_fault(f_out_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [DW-1:0] d, input logic [1:0] o, input logic [2:0] c);
      in_data    = d;
      in_offset  = o;
      in_control = c;
   endtask

   initial begin
      compared     = 0;
      mismatched   = 0;
      rst_n        = 1'b0;
      in_valid     = 1'b0;
      flt_in_valid = 1'b0;
      out_ready    = 1'b1;
      drive(32'h0, 2'd0, 3'd0);

      // reset state
      #12;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_need_second", {31'b0, need_second}, 32'd0);
      chk("rst_mis_fault", {30'b0, out_mis, out_fault}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      rst_n = 1'b1;

      // signed byte, aligned
      in_valid = 1'b1;
      drive(32'h12345680, 2'd0, 3'd2);
      tick();
      chk("sb0_valid", {31'b0, out_valid}, 32'd1);
      chk("sb0_data", out_data, 32'hFFFFFF80);
      chk("sb0_mis_fault", {30'b0, out_mis, out_fault}, 32'd0);

      // unsigned then signed byte at offset 3, back-to-back
      drive(32'hAB000000, 2'd3, 3'd4);
      tick();
      chk("ub3_data", out_data, 32'h000000AB);
      drive(32'hAB000000, 2'd3, 3'd2);
      tick();
      chk("sb3_data", out_data, 32'hFFFFFFAB);
      chk("sb3_valid", {31'b0, out_valid}, 32'd1);

      // signed half at offset 2 (fits), type 6 behaves as word
      drive(32'h87650000, 2'd2, 3'd1);
      tick();
      chk("sh2_data", out_data, 32'hFFFF8765);
      drive(32'hDEADBEEF, 2'd0, 3'd6);
      tick();
      chk("ctl6_word", out_data, 32'hDEADBEEF);

      // straddling unsigned half
      drive(32'h34000000, 2'd3, 3'd3);
      tick();
      chk("uh3_b1_ns", {31'b0, need_second}, 32'd1);
      chk("uh3_b1_valid", {31'b0, out_valid}, 32'd0);
      drive(32'h00000012, 2'd0, 3'd0);
      tick();
      chk("uh3_data", out_data, 32'h00001234);
      chk("uh3_mis", {31'b0, out_mis}, 32'd1);
      chk("uh3_ns", {31'b0, need_second}, 32'd0);
      chk("uh3_valid", {31'b0, out_valid}, 32'd1);

      // straddling word with a 3-cycle gap between beats
      drive(32'h56780000, 2'd2, 3'd0);
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      chk("w2_gap_ns", {31'b0, need_second}, 32'd1);
      chk("w2_gap_valid", {31'b0, out_valid}, 32'd0);
      in_valid = 1'b1;
      drive(32'h00001234, 2'd1, 3'd4);
      tick();
      chk("w2_data", out_data, 32'h12345678);
      chk("w2_mis", {31'b0, out_mis}, 32'd1);

      // back-pressure: hold for 5 cycles, then drain and refill together
      in_valid = 1'b0;
      tick();
      chk("bp_empty", {31'b0, out_valid}, 32'd0);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      drive(32'h000000C3, 2'd0, 3'd4);
      tick();
      chk("bp_load", out_data, 32'h000000C3);
      drive(32'h7F000000, 2'd3, 3'd2);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
         chk("bp_hold_data", out_data, 32'h000000C3);
         chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_ready_up", {31'b0, in_ready}, 32'd1);
      tick();
      chk("bp_refill_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_refill_data", out_data, 32'h0000007F);
      in_valid = 1'b0;
      tick();
      chk("bp_drained", {31'b0, out_valid}, 32'd0);

      // faulting instance: straddling word rejected, aligned byte fine
      flt_in_valid = 1'b1;
      drive(32'h11223344, 2'd1, 3'd0);
      tick();
      chk("flt_fault", {31'b0, f_out_fault}, 32'd1);
      chk("flt_data", f_out_data, 32'h0);
      chk("flt_valid", {31'b0, f_out_valid}, 32'd1);
      chk("flt_ns", {31'b0, f_need_second}, 32'd0);
      drive(32'h11223344, 2'd1, 3'd4);
      tick();
      chk("flt_ub1_data", f_out_data, 32'h00000033);
      chk("flt_ub1_fault", {31'b0, f_out_fault}, 32'd0);
      chk("flt_ub1_ns", {31'b0, f_need_second}, 32'd0);
      flt_in_valid = 1'b0;
      tick();
      chk("flt_drained", {31'b0, f_out_valid}, 32'd0);

      // reset while waiting for a second beat
      in_valid = 1'b1;
      drive(32'h34000000, 2'd3, 3'd3);
      tick();
      chk("rw_ns_before", {31'b0, need_second}, 32'd1);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #2;
      chk("rw_ns", {31'b0, need_second}, 32'd0);
      chk("rw_valid", {31'b0, out_valid}, 32'd0);
      chk("rw_data", out_data, 32'h0);
      #2;
      rst_n    = 1'b1;
      in_valid = 1'b1;
      drive(32'h00008001, 2'd0, 3'd1);
      tick();
      chk("rw_after_data", out_data, 32'hFFFF8001);
      chk("rw_after_mis", {31'b0, out_mis}, 32'd0);
      chk("rw_after_valid", {31'b0, out_valid}, 32'd1);
      in_valid = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
